// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the MIPS32 hazard/forwarding controller:
//   - ALU operand forward-select encodings
//   - load-use stall FSM state encoding
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM_WB = 2'b01;  // operand from MEM_WB write data
    localparam logic [1:0] FWD_EX_MEM = 2'b10;  // operand from EX_MEM ALU result

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit_if
// Bundle of pipeline-side signals seen by the hazard controller.
//   master : pipeline side (drives stage register fields, receives controls)
//   slave  : hazard controller
// Inputs to the controller : id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd,
//   ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
//   branch_taken
// Outputs of the controller: forward_a/b, pc_write, if_id_write,
//   id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt, flush_cnt
// ---------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic              branch_taken;

    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write,
               ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               branch_taken,
        input  forward_a, forward_b, pc_write, if_id_write, id_ex_bubble,
               if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write,
               ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               branch_taken,
        output forward_a, forward_b, pc_write, if_id_write, id_ex_bubble,
               if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Combinational ALU operand forward select for one source register.
//   i_src           source register of the EX-stage instruction
//   i_mem_rd/_we    EX_MEM destination and RegWrite
//   i_wb_rd/_we     MEM_WB destination and RegWrite
//   o_sel           FWD_RF / FWD_EX_MEM / FWD_MEM_WB
// The younger EX_MEM result has priority over MEM_WB; $0 is never forwarded.
// ---------------------------------------------------------------------------
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_reg_write,
    output logic [1:0]        o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_src != '0) begin
            if (i_mem_reg_write && (i_mem_rd == i_src)) begin
                o_sel = FWD_EX_MEM;
            end else if (i_wb_reg_write && (i_wb_rd == i_src)) begin
                o_sel = FWD_MEM_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
// Hazard and forwarding controller for the 5-stage MIPS32 pipeline.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    hazard_ctrl_unit_if.slave (stage fields in, pipeline controls out)
// Produces operand forward selects, load-use stalls of LOAD_LAT bubbles,
// RAW stalls when forwarding is disabled, taken-branch flushes (branches
// resolve in MEM) and saturating stall/flush event counters.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FWD_EN    = 1,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    hazard_ctrl_unit_if.slave bus
);

    // Remaining STALL cycles after the first (Mealy) stall cycle in RUN.
    localparam logic [2:0]       STALL_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_load_use;
    logic              w_raw_stall;
    logic              w_fsm_stall;
    logic              w_pc_write;
    logic              w_if_id_write;
    logic              w_bubble;
    logic              w_flush;

    function automatic logic f_raw(input logic [REG_AW-1:0] i_src,
                                   input logic [REG_AW-1:0] i_rd,
                                   input logic              i_we);
        return i_we && (i_src != '0) && (i_src == i_rd);
    endfunction

    forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src          (bus.ex_rs),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_reg_write(bus.mem_reg_write),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_reg_write (bus.wb_reg_write),
        .o_sel          (w_fwd_a)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src          (bus.ex_rt),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_reg_write(bus.mem_reg_write),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_reg_write (bus.wb_reg_write),
        .o_sel          (w_fwd_b)
    );

    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                        ((bus.ex_rd == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    // Without forwarding, any in-flight writer of an ID source holds ID.
    // rt only counts when the ID instruction actually reads it.
    always_comb begin
        logic w_rs_dep;
        logic w_rt_dep;
        w_rs_dep = f_raw(bus.id_rs, bus.ex_rd,  bus.ex_reg_write) ||
                   f_raw(bus.id_rs, bus.mem_rd, bus.mem_reg_write) ||
                   ((RF_BYPASS == 0) && f_raw(bus.id_rs, bus.wb_rd, bus.wb_reg_write));
        w_rt_dep = f_raw(bus.id_rt, bus.ex_rd,  bus.ex_reg_write) ||
                   f_raw(bus.id_rt, bus.mem_rd, bus.mem_reg_write) ||
                   ((RF_BYPASS == 0) && f_raw(bus.id_rt, bus.wb_rd, bus.wb_reg_write));
        w_raw_stall = (FWD_EN == 0) && (w_rs_dep || (bus.id_uses_rt && w_rt_dep));
    end

    // Load-use FSM: next state and its own stall request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fsm_stall = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_load_use) begin
                    w_fsm_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = STALL_INIT;
                    end
                end
            end
            ST_STALL: begin
                w_fsm_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
        if (bus.branch_taken) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end
    end

    // Pipeline controls: reset > taken branch > stall > idle.
    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        if (reset) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_flush       = 1'b1;
        end else if (bus.branch_taken) begin
            w_flush       = 1'b1;
        end else if (w_fsm_stall || w_raw_stall) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!w_pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (bus.branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign bus.forward_a    = ((FWD_EN == 0) || reset) ? FWD_RF : w_fwd_a;
    assign bus.forward_b    = ((FWD_EN == 0) || reset) ? FWD_RF : w_fwd_b;
    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.id_ex_bubble = w_bubble;
    assign bus.if_id_flush  = w_flush;
    assign bus.id_ex_flush  = w_flush;
    assign bus.ex_mem_flush = w_flush;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Two controllers share one stimulus set:
//   A: LOAD_LAT=3, forwarding on, 4-bit counters
//   B: LOAD_LAT=4, forwarding off, no register-file bypass, 32-bit counters
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    logic clk;
    logic rst_a;
    logic rst_b;

    logic [4:0] s_id_rs, s_id_rt, s_ex_rs, s_ex_rt, s_ex_rd, s_mem_rd, s_wb_rd;
    logic       s_uses_rt, s_ex_rw, s_ex_mr, s_mem_rw, s_wb_rw, s_br;

    int checks;
    int errors;

    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  if_a ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(32)) if_b ();

    assign if_a.id_rs = s_id_rs;         assign if_b.id_rs = s_id_rs;
    assign if_a.id_rt = s_id_rt;         assign if_b.id_rt = s_id_rt;
    assign if_a.id_uses_rt = s_uses_rt;  assign if_b.id_uses_rt = s_uses_rt;
    assign if_a.ex_rs = s_ex_rs;         assign if_b.ex_rs = s_ex_rs;
    assign if_a.ex_rt = s_ex_rt;         assign if_b.ex_rt = s_ex_rt;
    assign if_a.ex_rd = s_ex_rd;         assign if_b.ex_rd = s_ex_rd;
    assign if_a.ex_reg_write = s_ex_rw;  assign if_b.ex_reg_write = s_ex_rw;
    assign if_a.ex_mem_read = s_ex_mr;   assign if_b.ex_mem_read = s_ex_mr;
    assign if_a.mem_rd = s_mem_rd;       assign if_b.mem_rd = s_mem_rd;
    assign if_a.mem_reg_write = s_mem_rw; assign if_b.mem_reg_write = s_mem_rw;
    assign if_a.wb_rd = s_wb_rd;         assign if_b.wb_rd = s_wb_rd;
    assign if_a.wb_reg_write = s_wb_rw;  assign if_b.wb_reg_write = s_wb_rw;
    assign if_a.branch_taken = s_br;     assign if_b.branch_taken = s_br;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .FWD_EN(1), .RF_BYPASS(1), .CNT_W(4)) u_dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (if_a)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(4), .FWD_EN(0), .RF_BYPASS(0), .CNT_W(32)) u_dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] id_rs;  logic [4:0] id_rt;  logic uses_rt;
        logic [4:0] ex_rs;  logic [4:0] ex_rt;  logic [4:0] ex_rd;
        logic       ex_rw;  logic       ex_mr;
        logic [4:0] mem_rd; logic       mem_rw;
        logic [4:0] wb_rd;  logic       wb_rw;
        logic       br;
        logic [1:0] e_fa;   logic [1:0] e_fb;
        logic       e_pc;   logic       e_bub;  logic e_fl;
    } vec_t;

    vec_t vecs[12];

    task automatic idle();
        s_id_rs = '0; s_id_rt = '0; s_uses_rt = 1'b0;
        s_ex_rs = '0; s_ex_rt = '0; s_ex_rd = '0; s_ex_rw = 1'b0; s_ex_mr = 1'b0;
        s_mem_rd = '0; s_mem_rw = 1'b0; s_wb_rd = '0; s_wb_rw = 1'b0; s_br = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a negedge with both resets released.
    task automatic do_reset();
        idle();
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic load_use_hit();
        s_ex_mr = 1'b1; s_ex_rw = 1'b1; s_ex_rd = 5'd2;
        s_id_rs = 5'd2; s_id_rt = 5'd5; s_uses_rt = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            id_rs id_rt u  ex_rs ex_rt ex_rd rw mr mem_rd mrw wb_rd wrw br  fa     fb     pc bub fl
        vecs[0]  = '{5'd0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 1, 0, 0};
        vecs[1]  = '{5'd0, 5'd0, 0, 5'd3, 5'd0, 5'd0, 0, 0, 5'd3, 1, 5'd0, 0, 0, 2'b10, 2'b00, 1, 0, 0};
        vecs[2]  = '{5'd0, 5'd0, 0, 5'd3, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd3, 1, 0, 2'b01, 2'b00, 1, 0, 0};
        vecs[3]  = '{5'd0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 1, 0, 2'b00, 2'b00, 1, 0, 0};
        vecs[4]  = '{5'd0, 5'd0, 0, 5'd1, 5'd7, 5'd0, 0, 0, 5'd7, 1, 5'd7, 1, 0, 2'b00, 2'b10, 1, 0, 0};
        vecs[5]  = '{5'd0, 5'd0, 0, 5'd3, 5'd0, 5'd0, 0, 0, 5'd3, 0, 5'd9, 1, 0, 2'b00, 2'b00, 1, 0, 0};
        vecs[6]  = '{5'd0, 5'd0, 0, 5'd4, 5'd4, 5'd0, 0, 0, 5'd6, 1, 5'd4, 1, 0, 2'b01, 2'b01, 1, 0, 0};
        vecs[7]  = '{5'd2, 5'd5, 1, 5'd0, 5'd0, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[8]  = '{5'd6, 5'd2, 0, 5'd0, 5'd0, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 1, 0, 0};
        vecs[9]  = '{5'd6, 5'd2, 1, 5'd0, 5'd0, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[10] = '{5'd0, 5'd0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 1, 0, 0};
        vecs[11] = '{5'd0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 2'b00, 2'b00, 1, 0, 1};

        // Reset state, with a forwarding match present that must be masked.
        idle();
        rst_a = 1'b1;
        rst_b = 1'b1;
        s_ex_rs = 5'd3; s_mem_rd = 5'd3; s_mem_rw = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_pc_write",    32'(if_a.pc_write), 32'd0);
        chk("rst_if_id_write", 32'(if_a.if_id_write), 32'd0);
        chk("rst_flushes",     32'({if_a.if_id_flush, if_a.id_ex_flush, if_a.ex_mem_flush}), 32'h7);
        chk("rst_fwd_a",       32'(if_a.forward_a), 32'd0);
        chk("rst_bubble",      32'(if_a.id_ex_bubble), 32'd0);
        chk("rst_b_pc_write",  32'(if_b.pc_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle();
        #1;
        chk("post_rst_pc_write",  32'(if_a.pc_write), 32'd1);
        chk("post_rst_stall_cnt", 32'(if_a.stall_cnt), 32'd0);
        chk("post_rst_flush_cnt", 32'(if_a.flush_cnt), 32'd0);

        // Combinational vectors on A; inputs return to idle before each posedge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_id_rs = vecs[i].id_rs;   s_id_rt = vecs[i].id_rt;   s_uses_rt = vecs[i].uses_rt;
            s_ex_rs = vecs[i].ex_rs;   s_ex_rt = vecs[i].ex_rt;   s_ex_rd = vecs[i].ex_rd;
            s_ex_rw = vecs[i].ex_rw;   s_ex_mr = vecs[i].ex_mr;
            s_mem_rd = vecs[i].mem_rd; s_mem_rw = vecs[i].mem_rw;
            s_wb_rd = vecs[i].wb_rd;   s_wb_rw = vecs[i].wb_rw;   s_br = vecs[i].br;
            #1;
            chk($sformatf("v%0d_fwd_a", i),       32'(if_a.forward_a),    32'(vecs[i].e_fa));
            chk($sformatf("v%0d_fwd_b", i),       32'(if_a.forward_b),    32'(vecs[i].e_fb));
            chk($sformatf("v%0d_pc_write", i),    32'(if_a.pc_write),     32'(vecs[i].e_pc));
            chk($sformatf("v%0d_if_id_write", i), 32'(if_a.if_id_write),  32'(vecs[i].e_pc));
            chk($sformatf("v%0d_bubble", i),      32'(if_a.id_ex_bubble), 32'(vecs[i].e_bub));
            chk($sformatf("v%0d_flushes", i),
                32'({if_a.if_id_flush, if_a.id_ex_flush, if_a.ex_mem_flush}), 32'({3{vecs[i].e_fl}}));
            #1;
            idle();
        end

        // A: lw $2 in EX, add $4,$2,$5 in ID -> exactly 3 stall cycles.
        do_reset();
        load_use_hit();
        #1;
        chk("lu_c0_pc_write", 32'(if_a.pc_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("lu_c1_pc_write", 32'(if_a.pc_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("lu_c2_pc_write", 32'(if_a.pc_write), 32'd0);
        chk("lu_c2_bubble",   32'(if_a.id_ex_bubble), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("lu_c3_pc_write",  32'(if_a.pc_write), 32'd1);
        chk("lu_c3_bubble",    32'(if_a.id_ex_bubble), 32'd0);
        chk("lu_c3_stall_cnt", 32'(if_a.stall_cnt), 32'd3);

        // A: load-use hit coinciding with a taken branch.
        do_reset();
        load_use_hit();
        s_br = 1'b1;
        #1;
        chk("br_flushes",    32'({if_a.if_id_flush, if_a.id_ex_flush, if_a.ex_mem_flush}), 32'h7);
        chk("br_pc_write",   32'(if_a.pc_write), 32'd1);
        chk("br_if_id_write", 32'(if_a.if_id_write), 32'd1);
        chk("br_bubble",     32'(if_a.id_ex_bubble), 32'd0);
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("br_next_pc_write", 32'(if_a.pc_write), 32'd1);
        chk("br_flush_cnt",     32'(if_a.flush_cnt), 32'd1);
        chk("br_stall_cnt",     32'(if_a.stall_cnt), 32'd0);

        // B: reset arriving while in STALL (LOAD_LAT=4).
        do_reset();
        load_use_hit();
        #1;
        chk("bst_c0_pc_write", 32'(if_b.pc_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("bst_c1_pc_write", 32'(if_b.pc_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("bst_rst_pc_write", 32'(if_b.pc_write), 32'd0);
        chk("bst_rst_flushes",
            32'({if_b.if_id_flush, if_b.id_ex_flush, if_b.ex_mem_flush}), 32'h7);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("bst_after_pc_write",  32'(if_b.pc_write), 32'd1);
        chk("bst_after_bubble",    32'(if_b.id_ex_bubble), 32'd0);
        chk("bst_after_stall_cnt", if_b.stall_cnt, 32'd0);
        chk("bst_after_flush_cnt", if_b.flush_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bst_residual_pc_write", 32'(if_b.pc_write), 32'd1);

        // B: add $1 followed by a dependent add, no forwarding, no bypass.
        do_reset();
        s_id_rs = 5'd1; s_id_rt = 5'd5; s_uses_rt = 1'b1;
        s_ex_rd = 5'd1; s_ex_rw = 1'b1; s_ex_rs = 5'd7; s_ex_rt = 5'd8;
        #1;
        chk("nf_c0_pc_write", 32'(if_b.pc_write), 32'd0);
        chk("nf_c0_bubble",   32'(if_b.id_ex_bubble), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_ex_rd = '0; s_ex_rw = 1'b0; s_ex_rs = 5'd1; s_ex_rt = 5'd1;
        s_mem_rd = 5'd1; s_mem_rw = 1'b1;
        #1;
        chk("nf_c1_pc_write", 32'(if_b.pc_write), 32'd0);
        chk("nf_c1_fwd_a",    32'(if_b.forward_a), 32'd0);
        chk("nf_c1_fwd_b",    32'(if_b.forward_b), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_mem_rd = '0; s_mem_rw = 1'b0;
        s_wb_rd = 5'd1; s_wb_rw = 1'b1;
        #1;
        chk("nf_c2_pc_write", 32'(if_b.pc_write), 32'd0);
        chk("nf_c2_fwd_a",    32'(if_b.forward_a), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_wb_rd = '0; s_wb_rw = 1'b0;
        #1;
        chk("nf_c3_pc_write", 32'(if_b.pc_write), 32'd1);
        chk("nf_c3_stall_cnt", if_b.stall_cnt, 32'd3);

        // A: saturation of both 4-bit counters.
        do_reset();
        load_use_hit();
        repeat (14) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_stall_cnt_14", 32'(if_a.stall_cnt), 32'hE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_stall_cnt_hold", 32'(if_a.stall_cnt), 32'hF);
        idle();
        s_br = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_flush_cnt_hold", 32'(if_a.flush_cnt), 32'hF);
        chk("sat_stall_cnt_kept", 32'(if_a.stall_cnt), 32'hF);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
